// File: rtl/axiom_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axiom_apb_pkg
// Description : Shared types and constants for the APB4 master:
//               FSM state enum, pprot bit positions and the response record.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package axiom_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_master_state_e;

    // Bit positions inside pprot
    localparam int PROT_PRIV   = 0;
    localparam int PROT_NONSEC = 1;
    localparam int PROT_INSTR  = 2;

    // Widest supported data bus; narrower buses use the low bits of rdata.
    localparam int APB_MAX_DATA_WIDTH = 32;

    typedef struct packed {
        logic [APB_MAX_DATA_WIDTH-1:0] rdata;
        logic                          err;
        logic                          timeout;
    } apb_rsp_t;

endpackage
`default_nettype wire

// File: rtl/axiom_apb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : axiom_apb_watchdog
// Description : Stall counter for the APB ACCESS phase. Counts cycles in which
//               the slave holds pready low and flags the cycle in which the
//               TIMEOUT_CYCLES-th consecutive stall occurs.
// Ports       : pclk_i    - bus clock
//               presetn_i - asynchronous active-low reset
//               clear_i   - restart count (transfer SETUP phase)
//               enable_i  - stalled ACCESS cycle (count it)
//               expire_o  - this stalled cycle is the last one allowed
// Revision    : 1.0 - initial release
// ============================================================================
module axiom_apb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic pclk_i,
    input  logic presetn_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (enable_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge pclk_i or negedge presetn_i) begin
                if (!presetn_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // cnt_q holds the stalls already completed, so the current stall
            // is number cnt_q+1; abort when that reaches the limit.
            assign expire_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_wdog
            logic w_unused;
            assign w_unused = ^{pclk_i, presetn_i, clear_i, enable_i};
            assign expire_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/axiom_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : axiom_apb_master
// Description : Converts a valid/ready request channel into single APB4
//               SETUP/ACCESS transfers (one outstanding) and returns read
//               data / error status on a valid/ready response channel.
//               Optional watchdog aborts transfers the slave stalls.
// Ports       : pclk, presetn                      - clock, async low reset
//               req_valid/ready/addr/write/wdata/strb/prot - request channel
//               rsp_valid/ready/rdata/err/timeout  - response channel
//               psel/penable/pwrite/paddr/pwdata/pwstrb/pprot - APB outputs
//               prdata/pslverr/pready              - APB slave returns
// Revision    : 1.0 - initial release
// ============================================================================
module axiom_apb_master
    import axiom_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      pclk,
    input  logic                      presetn,
    // request channel
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic                      req_write,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_strb,
    input  logic [2:0]                req_prot,
    // response channel
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    // APB
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pwstrb,
    output logic [2:0]                pprot,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr,
    input  logic                      pready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    apb_master_state_e state_q;
    apb_master_state_e state_d;
    logic              req_ready_q;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_WIDTH-1:0] pwstrb_q;
    logic [2:0]            pprot_q;

    apb_rsp_t rsp_q;
    apb_rsp_t rsp_d;

    logic w_req_fire;
    logic w_xfer_done;
    logic w_wdog_expire;
    logic w_psel;
    logic w_penable;
    logic w_rsp_valid;

    assign w_req_fire  = (state_q == IDLE) && req_valid && req_ready_q;
    // pslverr/prdata only qualify when psel & penable & pready
    assign w_xfer_done = (state_q == ACCESS) && pready;

    axiom_apb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .pclk_i    (pclk),
        .presetn_i (presetn),
        .clear_i   (state_q == SETUP),
        .enable_i  ((state_q == ACCESS) && !pready),
        .expire_o  (w_wdog_expire)
    );

    // ------------------------------------------------------------------
    // FSM: state register. req_ready is a registered decode of the next
    // state, so it is low out of reset and rises on the first clock edge.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == IDLE);
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_req_fire)                 state_d = SETUP;
            SETUP:                                   state_d = ACCESS;
            ACCESS:  if (pready || w_wdog_expire)    state_d = RESP;
            RESP:    if (rsp_ready)                  state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    // FSM: outputs decoded from the state register
    always_comb begin
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_rsp_valid = 1'b0;
        case (state_q)
            SETUP:  w_psel = 1'b1;
            ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
            end
            RESP:   w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Response capture: slave completion wins over a same-cycle expiry
    // because expiry is only raised while pready is low.
    always_comb begin
        rsp_d = rsp_q;
        if (w_xfer_done) begin
            rsp_d.rdata   = '0;
            if (!pwrite_q) begin
                rsp_d.rdata[DATA_WIDTH-1:0] = prdata;
            end
            rsp_d.err     = pslverr;
            rsp_d.timeout = 1'b0;
        end else if (w_wdog_expire) begin
            rsp_d.rdata   = '0;
            rsp_d.err     = 1'b1;
            rsp_d.timeout = 1'b1;
        end
    end

    // Transfer attributes latched on request acceptance and held for the
    // whole transfer. Reads drive zero write data and strobes.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pwstrb_q <= '0;
            pprot_q  <= '0;
            rsp_q    <= '0;
        end else begin
            if (w_req_fire) begin
                paddr_q  <= req_addr;
                pwrite_q <= req_write;
                pwdata_q <= req_write ? req_wdata : '0;
                pwstrb_q <= req_write ? req_strb  : '0;
                pprot_q  <= req_prot;
            end
            rsp_q <= rsp_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign psel        = w_psel;
    assign penable     = w_penable;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pwstrb      = pwstrb_q;
    assign pprot       = pprot_q;
    assign rsp_valid   = w_rsp_valid;
    assign rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule
`default_nettype wire
